branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the ID-stage branch condition handler in the MIPS pipeline.
- Resolves every conditional branch class from ALU flags and drives the taken decision, the link request and the IF/ID flush.
- Adds a PC-indexed table of 2-bit saturating predictors for the fetch stage, misprediction detection, predictor training, and saturating branch/mispredict statistics counters.
- Sits between fetch (prediction lookup) and ID/EX (resolution); all resolution outputs are registered.

Parameters:
BHT_ENTRIES, 16, number of predictor entries; power of two, 2..256
PC_W, 32, program counter width
CTR_INIT, 2'b01, reset value of every predictor counter (weakly not-taken)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
fetch_pc  in  PC_W  PC of the instruction being fetched
predict_taken  out  1  prediction for fetch_pc; combinational = bht[idx(fetch_pc)][1]
resolve_valid  in  1  a branch-candidate instruction is presented for resolution this cycle
instruction  in  32  instruction being resolved
branch_pc  in  PC_W  PC of the instruction being resolved
predicted  in  1  prediction carried down the pipe with this instruction
z_flag  in  1  zero flag of the branch comparison (rs-rt, or rs for compare-with-zero forms)
n_flag  in  1  negative flag of the same comparison
ch_out  out  1  registered: branch taken
link_out  out  1  registered: taken-or-not link class (BLTZAL/BGEZAL); write $31
is_branch  out  1  registered: the last resolved instruction was a legal branch
mispredict  out  1  registered: taken differs from predicted
if_id_reset  out  1  registered one-cycle flush pulse; equals mispredict
branch_count  out  CNT_W  saturating count of legal resolved branches
mispredict_count  out  CNT_W  saturating count of mispredictions

Behaviour:
- Index: idx(pc) = pc[log2(BHT_ENTRIES)+1 : 2]; word-aligned, low two bits ignored.
- Decode (opcode = instruction[31:26], rt = instruction[20:16]); cond is the taken condition:
  - 000100 BEQ: cond = z
  - 000101 BNE: cond = !z
  - 000111 BGTZ, legal only if rt = 0: cond = !z && !n
  - 000110 BLEZ, legal only if rt = 0: cond = z || n
  - 000001 REGIMM, rt = 00000 BLTZ: cond = n
  - REGIMM, rt = 00001 BGEZ: cond = !n
  - REGIMM, rt = 10000 BLTZAL: cond = n, link
  - REGIMM, rt = 10001 BGEZAL: cond = !n, link; with rs = $0 this is BAL (flags z=1, n=0 give taken)
  - Any other opcode/rt combination is not a branch: is_branch = 0, taken = 0, no training, no mispredict, no count.
- Resolution: on the clk edge with resolve_valid = 1, register
  - is_branch
  - ch_out = is_branch && cond
  - link_out = is_branch && link class
  - mispredict = is_branch && (ch_out_next != predicted)
  - if_id_reset = mispredict
- Latency: exactly one cycle. Outputs hold for one cycle only; with resolve_valid = 0 all of them register 0 on the next edge. No latches: every output is defined every cycle.
- Training, when a legal branch resolves:
  - bht[idx(branch_pc)] increments (saturates at 11) if taken, decrements (saturates at 00) if not.
  - Read-before-write: a same-cycle fetch lookup of the same index returns the pre-update value; the new value is visible from the next cycle.
- Statistics:
  - branch_count += 1 per legal branch.
  - mispredict_count += 1 per misprediction.
  - Both saturate at 2^CNT_W - 1; no wrap.
- Reset (asynchronous, reset_n = 0):
  - Every bht entry = CTR_INIT; all registered outputs and both counters = 0.
  - An in-flight resolution is discarded; no table update.
  - predict_taken reflects CTR_INIT[1] immediately.
  - Release is synchronous to the next clk edge.
- Back-to-back resolutions on consecutive cycles to the same index each train in order; the second sees the first's update.

Test Plan:
1. Reset, then fetch_pc = 0x0040_0010 -> predict_taken = 0; counts 0; all outputs 0.
2. BEQ (0x1000_0003) with z=1, predicted=0, branch_pc = 0x0040_0010 -> next cycle ch_out = 1, mispredict = 1, if_id_reset = 1 for one cycle. bht[4] = 10, so predict_taken for 0x0040_0010 = 1. branch_count = 1, mispredict_count = 1.
3. BGTZ with rt = 5 (0x1CA5_0002), z=0, n=0 -> is_branch = 0, ch_out = 0, no count change, bht unchanged.
4. BGEZAL rs=$0 (0x0411_0004), z=1, n=0, predicted=1 -> ch_out = 1, link_out = 1, mispredict = 0.
5. Same index trained taken 3 times from 01 -> saturates at 11. Then one not-taken -> 10, predict_taken stays 1. A lookup in the training cycle returns the old value.
6. Assert reset_n = 0 mid-cycle while resolve_valid = 1 with a mispredicting BNE -> outputs 0 immediately, bht all 01, counts 0. Set CNT_W = 2 and resolve 5 branches -> branch_count holds at 3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves MIPS conditional branches from ALU flags, predicts with a 2-bit BHT, trains it and counts branches/mispredicts
module branch_resolve_unit #(
  parameter int BHT_ENTRIES = 16,
  parameter int PC_W = 32,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             predict_taken,
  input  logic             resolve_valid,
  input  logic [31:0]      instruction,
  input  logic [PC_W-1:0]  branch_pc,
  input  logic             predicted,
  input  logic             z_flag,
  input  logic             n_flag,
  output logic             ch_out,
  output logic             link_out,
  output logic             is_branch,
  output logic             mispredict,
  output logic             if_id_reset,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0] bht [BHT_ENTRIES];
  logic [IW-1:0] f_idx, b_idx;
  logic [5:0] opcode;
  logic [4:0] rt;
  logic legal, cond, link, br, mis;
  logic [1:0] cur, nxt;
  assign opcode = instruction[31:26];
  assign rt = instruction[20:16];
  assign f_idx = fetch_pc[IW+1:2];
  assign b_idx = branch_pc[IW+1:2];
  assign predict_taken = bht[f_idx][1];
  always_comb begin
    legal = 1'b0;
    cond = 1'b0;
    link = 1'b0;
    case (opcode)
      6'b000100: begin legal = 1'b1; cond = z_flag; end
      6'b000101: begin legal = 1'b1; cond = !z_flag; end
      6'b000111: begin legal = rt == 5'd0; cond = !z_flag && !n_flag; end
      6'b000110: begin legal = rt == 5'd0; cond = z_flag || n_flag; end
      6'b000001: begin
        legal = rt[3:1] == 3'b000;
        cond = rt[0] ? !n_flag : n_flag;
        link = rt[4];
      end
      default: ;
    endcase
  end
  assign br = resolve_valid && legal;
  assign mis = br && (cond != predicted);
  assign cur = bht[b_idx];
  assign nxt = cond ? (cur == 2'b11 ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
    end else if (br) begin
      bht[b_idx] <= nxt;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_out <= 1'b0;
      link_out <= 1'b0;
      is_branch <= 1'b0;
      mispredict <= 1'b0;
      if_id_reset <= 1'b0;
      branch_count <= '0;
      mispredict_count <= '0;
    end else begin
      ch_out <= br && cond;
      link_out <= br && link;
      is_branch <= br;
      mispredict <= mis;
      if_id_reset <= mis;
      branch_count <= (br && ~&branch_count) ? branch_count + CNT_W'(1) : branch_count;
      mispredict_count <= (mis && ~&mispredict_count) ? mispredict_count + CNT_W'(1) : mispredict_count;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] fetch_pc = '0, instruction = '0, branch_pc = '0;
  logic resolve_valid = 1'b0, predicted = 1'b0, z_flag = 1'b0, n_flag = 1'b0;
  logic predict_taken, ch_out, link_out, is_branch, mispredict, if_id_reset;
  logic [15:0] branch_count, mispredict_count;
  logic s_pt, s_ch, s_lk, s_ib, s_mp, s_ir;
  logic [1:0] s_bc, s_mc;
  typedef struct {
    logic isb, ch, lk, mp;
    int bc, mc;
    string name;
  } exp_t;
  exp_t q[$];
  logic [1:0] mbht [16];
  int mbc, mmc;
  int errors = 0, checks = 0;
  logic rv_q;

  branch_resolve_unit dut (
    .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc), .predict_taken(predict_taken),
    .resolve_valid(resolve_valid), .instruction(instruction), .branch_pc(branch_pc),
    .predicted(predicted), .z_flag(z_flag), .n_flag(n_flag), .ch_out(ch_out),
    .link_out(link_out), .is_branch(is_branch), .mispredict(mispredict),
    .if_id_reset(if_id_reset), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_unit #(.CNT_W(2)) u_small (
    .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc), .predict_taken(s_pt),
    .resolve_valid(resolve_valid), .instruction(instruction), .branch_pc(branch_pc),
    .predicted(predicted), .z_flag(z_flag), .n_flag(n_flag), .ch_out(s_ch),
    .link_out(s_lk), .is_branch(s_ib), .mispredict(s_mp),
    .if_id_reset(s_ir), .branch_count(s_bc), .mispredict_count(s_mc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mbht[i] = 2'b01;
    mbc = 0;
    mmc = 0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic pred, input logic z,
                       input logic n, input logic ei, input logic ec, input logic el, input string name);
    exp_t e;
    int ix;
    @(posedge clk);
    #1;
    instruction = ins; branch_pc = pc; fetch_pc = pc; predicted = pred;
    z_flag = z; n_flag = n; resolve_valid = 1'b1;
    ix = int'(pc[5:2]);
    #1 chk({name, " lookup"}, {31'd0, predict_taken}, {31'd0, mbht[ix][1]});
    e.isb = ei; e.ch = ec; e.lk = el; e.mp = ei && (ec != pred);
    if (ei) begin
      mbc++;
      if (e.mp) mmc++;
      mbht[ix] = ec ? (mbht[ix] == 2'b11 ? 2'b11 : mbht[ix] + 2'd1)
                    : (mbht[ix] == 2'b00 ? 2'b00 : mbht[ix] - 2'd1);
    end
    e.bc = mbc; e.mc = mmc; e.name = name;
    q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1 resolve_valid = 1'b0;
  endtask

  task automatic chk_pred(input logic [31:0] pc, input string name);
    fetch_pc = pc;
    #1 chk(name, {31'd0, predict_taken}, {31'd0, mbht[int'(pc[5:2])][1]});
  endtask

  always @(posedge clk or negedge reset_n)
    if (!reset_n) rv_q <= 1'b0;
    else rv_q <= resolve_valid;

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (rv_q) begin
        if (q.size() == 0) chk("scoreboard empty", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk({e.name, " is_branch"}, {31'd0, is_branch}, {31'd0, e.isb});
          chk({e.name, " ch_out"}, {31'd0, ch_out}, {31'd0, e.ch});
          chk({e.name, " link_out"}, {31'd0, link_out}, {31'd0, e.lk});
          chk({e.name, " mispredict"}, {31'd0, mispredict}, {31'd0, e.mp});
          chk({e.name, " if_id_reset"}, {31'd0, if_id_reset}, {31'd0, e.mp});
          chk({e.name, " branch_count"}, {16'd0, branch_count}, e.bc);
          chk({e.name, " mispredict_count"}, {16'd0, mispredict_count}, e.mc);
          chk({e.name, " small branch_count"}, {30'd0, s_bc}, e.bc > 3 ? 3 : e.bc);
          chk({e.name, " small mispredict_count"}, {30'd0, s_mc}, e.mc > 3 ? 3 : e.mc);
        end
      end else begin
        chk("idle outputs", {27'd0, ch_out, link_out, is_branch, mispredict, if_id_reset}, 32'd0);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {27'd0, ch_out, link_out, is_branch, mispredict, if_id_reset}, 32'd0);
    chk("reset counts", {branch_count, mispredict_count}, 32'd0);
    chk_pred(32'h0040_0010, "reset predict");
    @(negedge clk);
    #1 reset_n = 1'b1;
    issue(32'h1000_0003, 32'h0040_0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "beq taken");
    idle();
    chk_pred(32'h0040_0010, "beq trained predict");
    issue(32'h1CA5_0002, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bgtz rt5 illegal");
    issue(32'h0411_0004, 32'h0040_0020, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "bal");
    issue(32'h1000_0001, 32'h0040_0030, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "train t1");
    issue(32'h1000_0001, 32'h0040_0030, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "train t2");
    issue(32'h1000_0001, 32'h0040_0030, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "train t3");
    issue(32'h1000_0001, 32'h0040_0030, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "train nt");
    idle();
    chk_pred(32'h0040_0030, "after saturate+nt predict");
    issue(32'h1400_0001, 32'h0040_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "bne taken");
    issue(32'h1400_0001, 32'h0040_0004, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "bne not");
    issue(32'h1800_0001, 32'h0040_0008, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "blez neg");
    issue(32'h1800_0001, 32'h0040_0008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "blez pos");
    issue(32'h1801_0001, 32'h0040_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "blez rt1 illegal");
    issue(32'h1C00_0001, 32'h0040_000C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "bgtz pos");
    issue(32'h1C00_0001, 32'h0040_000C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "bgtz zero");
    issue(32'h0400_0001, 32'h0040_0014, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "bltz neg");
    issue(32'h0401_0001, 32'h0040_0014, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "bgez neg");
    issue(32'h0410_0001, 32'h0040_0018, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "bltzal not");
    issue(32'h0402_0001, 32'h0040_0018, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "regimm rt2 illegal");
    issue(32'h0800_0001, 32'h0040_001C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "jump illegal");
    idle();
    issue(32'h1400_0001, 32'h0040_0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "bne pre-reset");
    issue(32'h1400_0001, 32'h0040_0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "bne discarded");
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async reset outputs", {27'd0, ch_out, link_out, is_branch, mispredict, if_id_reset}, 32'd0);
    chk("async reset counts", {branch_count, mispredict_count}, 32'd0);
    chk("async reset small counts", {28'd0, s_bc, s_mc}, 32'd0);
    q.delete();
    model_reset();
    for (int i = 0; i < 16; i++) chk_pred(32'h0040_0000 + 32'(i * 4), "post-reset bht");
    @(posedge clk);
    #1 resolve_valid = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++)
      issue(32'h1000_0001, 32'h0040_0044, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "saturate small");
    idle();
    chk_pred(32'h0040_0044, "post-reset trained predict");
    repeat (2) @(posedge clk);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("scoreboard drain", q.size(), 32'd0);
    #1 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
